booth_mult_seq: RTL and testbench
=================================

// Module: booth_mult_seq
// PURPOSE
//  Parametrised sequential radix-2 Booth multiplier for signed two's-complement operands.
//  Uses one generalised add/subtract datapath: an XOR array on the addend plus carry-in gives A+B or A-B.
//  Performs one Booth iteration per clock, with a start/busy/done handshake.
//  Top-level arithmetic unit of the Booth Algorithm project; replaces the gate-level combinational build.
// PARAMETERS
//  WIDTH   8   operand width in bits (>=2); product is 2*WIDTH bits
// PORTS
//  clk           in   1          rising-edge clock
//  rst           in   1          synchronous, active-high reset
//  start         in   1          request; sampled only in IDLE
//  multiplicand  in   WIDTH      signed M; captured on accepted start
//  multiplier    in   WIDTH      signed Q; captured on accepted start
//  busy          out  1          high in RUN
//  done          out  1          one-cycle pulse when product becomes valid
//  product       out  2*WIDTH    signed M*Q; held until next completion
// BEHAVIOUR
//  Reset
//   - On clk edge with rst=1: state=IDLE; busy=0, done=0, product=0; internal regs cleared.
//   - rst has priority over everything, including mid-RUN: the operation is aborted and no done pulse is issued.
//  States
//   IDLE
//    - start=1: load M_ext={M[W-1],M} (WIDTH+1 bits), A=0 (WIDTH+1 bits), Q=multiplier, Q_1=0, cnt=WIDTH.
//    - Then go to RUN.
//   RUN
//    - Each cycle, examine {Q[0],Q_1}:
//      - 01: A=A+M_ext.
//      - 10: A=A-M_ext, computed as A + (M_ext ^ {W+1{1}}) + 1.
//      - 00/11: no change.
//    - Then arithmetic-shift {A,Q,Q_1} right by 1; A MSB is replicated.
//    - cnt decrements; after the cnt==1 iteration go to DONE.
//   DONE
//    - product <= {A[W-1:0],Q}.
//    - done=1 for exactly this cycle; busy=0.
//    - Return to IDLE next cycle.
//  Latency and handshake
//   - start accepted on edge 0 -> WIDTH RUN cycles -> done=1 during cycle WIDTH+1.
//   - Next start may be accepted the cycle after DONE. Minimum issue interval is WIDTH+2 cycles.
//  Boundary conditions
//   - start while busy or in DONE: ignored. Inputs are not re-sampled, and the in-flight result is unaffected.
//   - Operands may change freely after acceptance.
//   - Accumulator is WIDTH+1 bits, so M=-2^(W-1) cannot overflow; every result is exact in 2*WIDTH bits.
//   - Intermediate add/sub carry-out is discarded.
//   - product is updated only in DONE; it holds its old value during RUN.
//   - start held high continuously: a new operation begins every WIDTH+2 cycles.
// STRUCTURE
//  - Shared include booth_defs.vh holds:
//    - state encodings ST_IDLE/ST_RUN/ST_DONE (2 bits);
//    - Booth pair codes BOOTH_ADD=2'b01, BOOTH_SUB=2'b10.
//  - Sub-module booth_addsub #(N): inputs a[N], b[N], sub; output y[N].
//    - y = a + (b ^ {N{sub}}) + sub.
//    - This is the N-bit XOR-array successor; instantiate it with N=WIDTH+1.
//  - Counter width is $clog2(WIDTH+1). FSM and datapath live in one always block plus the sub-module.
// TESTING (WIDTH=8 unless stated)
//  1) M=3, Q=5 pulsed start -> busy for 8 cycles; done at cycle 9; product=16'h000F.
//  2) M=-7, Q=6 -> product=16'hFFD6 (-42); M=6, Q=-7 gives the same value.
//  3) M=-128, Q=-128 -> 16'h4000; M=127, Q=-128 -> 16'hC080; M=0, Q=-1 -> 16'h0000.
//  4) Second start with different operands at cycle 3 of a run -> ignored; first result correct; exactly one done pulse.
//  5) rst=1 at cycle 4 of a run -> next cycle busy=0, done=0, product=0, and no done appears.
//     A fresh start then completes normally.
//  6) start held high, WIDTH=16, random operands x1000 -> each done matches $signed reference; done spacing is 18 cycles.

Source files
------------

// File: rtl/booth_mult_seq_pkg.sv
//------------------------------------------------------------------------------
// Module   : booth_mult_seq_pkg
// Purpose  : Shared definitions for the sequential radix-2 Booth multiplier:
//            controller state encoding and Booth pair codes.
// Contents : state_t          - ST_IDLE / ST_RUN / ST_DONE (2 bits)
//            BOOTH_ADD/SUB    - {Q[0],Q_1} pair codes selecting add/subtract
//            booth_uses_addend- true when the pair code calls for +/-M
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package booth_mult_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    // Pairs 00 and 11 leave the accumulator unchanged.
    function automatic logic booth_uses_addend(input logic [1:0] pair);
        return (pair == BOOTH_ADD) || (pair == BOOTH_SUB);
    endfunction

endpackage

`default_nettype wire

// File: rtl/booth_addsub.sv
//------------------------------------------------------------------------------
// Module   : booth_addsub
// Purpose  : N-bit generalised adder/subtractor. The addend passes through an
//            XOR array controlled by sub, and sub is also the carry-in, so the
//            result is a+b when sub=0 and a-b when sub=1. Carry-out is dropped.
// Ports    : a   [N-1:0] in   first operand
//            b   [N-1:0] in   second operand
//            sub         in   1 = subtract
//            y   [N-1:0] out  a + (b ^ {N{sub}}) + sub
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module booth_addsub #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] y
);

    logic [N-1:0] w_b_inv;
    logic [N-1:0] w_cin;

    assign w_b_inv = b ^ {N{sub}};
    assign w_cin   = {{(N-1){1'b0}}, sub};
    assign y       = a + w_b_inv + w_cin;

endmodule

`default_nettype wire

// File: rtl/booth_mult_seq.sv
//------------------------------------------------------------------------------
// Module   : booth_mult_seq
// Purpose  : Sequential radix-2 Booth multiplier for signed two's-complement
//            operands, one Booth iteration per clock, start/busy/done handshake.
// Ports    : clk                   in   rising-edge clock
//            rst                   in   synchronous active-high reset
//            start                 in   request, sampled only in IDLE
//            multiplicand [W-1:0]  in   signed M, captured on accepted start
//            multiplier   [W-1:0]  in   signed Q, captured on accepted start
//            busy                  out  high while iterating
//            done                  out  one-cycle pulse, product valid
//            product    [2W-1:0]   out  signed M*Q, held until next completion
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module booth_mult_seq
    import booth_mult_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int c_cnt_w = $clog2(WIDTH + 1);

    state_t               r_state;
    logic [WIDTH:0]       r_m;      // sign-extended multiplicand
    logic [WIDTH:0]       r_a;      // accumulator, one guard bit wide
    logic [WIDTH-1:0]     r_q;
    logic                 r_q1;
    logic [c_cnt_w-1:0]   r_cnt;

    logic [1:0]           w_pair;
    logic                 w_sub;
    logic [WIDTH:0]       w_addend;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_a_sh;
    logic [WIDTH-1:0]     w_q_sh;

    assign w_pair   = {r_q[0], r_q1};
    assign w_sub    = (w_pair == BOOTH_SUB);
    // A zero addend with sub=0 turns the adder into a pass-through for 00/11.
    assign w_addend = booth_uses_addend(w_pair) ? r_m : '0;

    booth_addsub #(
        .N   (WIDTH + 1)
    ) u_addsub (
        .a   (r_a),
        .b   (w_addend),
        .sub (w_sub),
        .y   (w_sum)
    );

    // Arithmetic right shift of {A,Q,Q_1}; the outgoing Q[0] becomes Q_1.
    assign w_a_sh = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign w_q_sh = {w_sum[0], r_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_m     <= '0;
            r_a     <= '0;
            r_q     <= '0;
            r_q1    <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_m     <= {multiplicand[WIDTH-1], multiplicand};
                        r_a     <= '0;
                        r_q     <= multiplier;
                        r_q1    <= 1'b0;
                        r_cnt   <= c_cnt_w'(WIDTH);
                        busy    <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a   <= w_a_sh;
                    r_q   <= w_q_sh;
                    r_q1  <= r_q[0];
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == c_cnt_w'(1)) begin
                        // Product is registered from the final shift so it is
                        // valid in the same cycle done is high.
                        product <= {w_a_sh[WIDTH-1:0], w_q_sh};
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_booth_mult_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_booth_mult_seq
// Purpose  : Self-checking bench for booth_mult_seq at WIDTH=8 (directed cases)
//            and WIDTH=16 (start held high, random operands).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_booth_mult_seq;

    logic        clk;
    logic        rst;

    logic        start8;
    logic [7:0]  mc8, mq8;
    logic        busy8, done8;
    logic [15:0] product8;

    logic        start16;
    logic [15:0] mc16, mq16;
    logic        busy16, done16;
    logic [31:0] product16;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;
    int cyc_cnt = 0;

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .rst          (rst),
        .start        (start8),
        .multiplicand (mc8),
        .multiplier   (mq8),
        .busy         (busy8),
        .done         (done8),
        .product      (product8)
    );

    booth_mult_seq #(.WIDTH(16)) dut16 (
        .clk          (clk),
        .rst          (rst),
        .start        (start16),
        .multiplicand (mc16),
        .multiplier   (mq16),
        .busy         (busy16),
        .done         (done16),
        .product      (product16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a request is taken only when idle; the result is the
    // signed product, reported WIDTH+1 cycles after acceptance.
    int          m8_cyc = 0;
    logic [15:0] m8_res, m8_prod = '0;
    int          m16_cyc = 0;
    logic [31:0] m16_res, m16_prod = '0;

    always @(posedge clk) begin
        cyc_cnt++;
        if (rst) begin
            m8_cyc  = 0;
            m8_prod = '0;
            m16_cyc = 0;
            m16_prod = '0;
        end else begin
            if (m8_cyc == 0) begin
                if (start8) begin
                    m8_cyc = 1;
                    m8_res = $signed(mc8) * $signed(mq8);
                end
            end else if (m8_cyc == 9) begin
                m8_cyc = 0;
            end else begin
                m8_cyc++;
                if (m8_cyc == 9) m8_prod = m8_res;
            end

            if (m16_cyc == 0) begin
                if (start16) begin
                    m16_cyc = 1;
                    m16_res = $signed(mc16) * $signed(mq16);
                end
            end else if (m16_cyc == 17) begin
                m16_cyc = 0;
            end else begin
                m16_cyc++;
                if (m16_cyc == 17) m16_prod = m16_res;
            end
        end
    end

    int d16_n = 0;
    int d16_last = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy8",    {31'b0, busy8}, {31'b0, (m8_cyc >= 1 && m8_cyc <= 8)});
            chk("done8",    {31'b0, done8}, {31'b0, (m8_cyc == 9)});
            chk("product8", {16'b0, product8}, {16'b0, m8_prod});
            chk("busy16",   {31'b0, busy16}, {31'b0, (m16_cyc >= 1 && m16_cyc <= 16)});
            chk("done16",   {31'b0, done16}, {31'b0, (m16_cyc == 17)});
            chk("product16", product16, m16_prod);
            if (done16) begin
                if (d16_n > 0) chk("spacing16", cyc_cnt - d16_last, 18);
                d16_last = cyc_cnt;
                d16_n++;
            end
        end
    end

    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input string nm);
        int cyc;
        @(negedge clk);
        start8 = 1'b1; mc8 = a; mq8 = b;
        @(negedge clk);
        start8 = 1'b0; mc8 = 8'($urandom); mq8 = 8'($urandom);
        cyc = 1;
        while (!done8 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_latency"}, cyc, 9);
        chk({nm, "_product"}, {16'b0, product8}, {16'b0, exp});
    endtask

    initial begin
        int cyc;
        int nd;
        rst = 1'b1;
        start8 = 1'b0; mc8 = '0; mq8 = '0;
        start16 = 1'b0; mc16 = '0; mq16 = '0;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1;
        chk("reset_busy",    {31'b0, busy8}, 32'd0);
        chk("reset_done",    {31'b0, done8}, 32'd0);
        chk("reset_product", {16'b0, product8}, 32'd0);
        rst = 1'b0;

        run8(8'd3,  8'd5,  16'h000F, "m3_q5");
        run8(8'hF9, 8'h06, 16'hFFD6, "mneg7_q6");
        run8(8'h06, 8'hF9, 16'hFFD6, "m6_qneg7");
        run8(8'h80, 8'h80, 16'h4000, "mmin_qmin");
        run8(8'h7F, 8'h80, 16'hC080, "mmax_qmin");
        run8(8'h00, 8'hFF, 16'h0000, "m0_qneg1");

        // Second request arriving mid-run must be ignored.
        @(negedge clk);
        start8 = 1'b1; mc8 = 8'd5; mq8 = 8'd9;
        @(negedge clk);
        start8 = 1'b0;
        cyc = 1; nd = 0;
        repeat (20) begin
            if (cyc == 3) begin
                start8 = 1'b1; mc8 = 8'd100; mq8 = 8'hFD;
            end else begin
                start8 = 1'b0;
            end
            if (done8) begin
                nd++;
                chk("ignored_start_product", {16'b0, product8}, 32'h002D);
            end
            @(negedge clk);
            cyc++;
        end
        chk("ignored_start_done_count", nd, 1);

        // Reset in the middle of a run aborts it.
        @(negedge clk);
        start8 = 1'b1; mc8 = 8'd11; mq8 = 8'hF3;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy",    {31'b0, busy8}, 32'd0);
        chk("abort_done",    {31'b0, done8}, 32'd0);
        chk("abort_product", {16'b0, product8}, 32'd0);
        rst = 1'b0;
        nd = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8) nd++;
        end
        chk("abort_no_done", nd, 0);
        run8(8'hFB, 8'hFB, 16'h0019, "after_abort");

        // Continuous requests at WIDTH=16 with changing operands.
        @(negedge clk);
        start16 = 1'b1;
        mc16 = 16'($urandom); mq16 = 16'($urandom);
        for (int i = 0; i < 20000 && d16_n < 1000; i++) begin
            @(negedge clk);
            mc16 = 16'($urandom); mq16 = 16'($urandom);
        end
        chk("stream16_done_count", d16_n, 1000);
        start16 = 1'b0;
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
